dmem_arbiter: RTL and testbench

- Shares the single data-memory port among the instruction-fetch, load-FU and store-FU requesters.
- Replaces the combinational load-first priority in the EX stage with a sequential arbiter. The arbiter adds anti-starvation counters, an outstanding-tag table and registered response routing.
- Sits between the FUs/fetch and the Dmem bus. Its command outputs drive proc2Dmem directly.

---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_tag_table.sv | 40 ++++
 rtl/dmem_arbiter.sv | 84 ++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter
// Holds the bus command and access-size types, requester indices, the request
// packet and the tag-table entry layout.
package dmem_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REQ = 3;
  localparam int STARVE_LIMIT = 4;
  localparam int NUM_TAGS = 16;
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int REQ_FETCH = 0;
  localparam int REQ_LD = 1;
  localparam int REQ_ST = 2;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
  typedef struct packed {
    BUS_COMMAND cmd;
    logic [XLEN-1:0] addr;
    logic [63:0] data;
    MEM_SIZE size;
  } DMEM_REQ_PACKET;
  typedef struct packed {
    logic valid;
    logic [OWN_W-1:0] owner;
    logic drop;
  } DMEM_TAG_ENTRY;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory-side bus bundle for dmem_arbiter
// master: arbiter view (requests and memory replies in; acks, responses and
// proc2Dmem command out). slave: the opposite side (requesters + memory).
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] rsp_valid;
  BUS_COMMAND [NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0][XLEN-1:0] req_addr;
  logic [NUM_REQ-1:0][63:0] req_data;
  MEM_SIZE [NUM_REQ-1:0] req_size;
  logic [63:0] rsp_data;
  BUS_COMMAND proc2Dmem_command;
  logic [XLEN-1:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  MEM_SIZE proc2Dmem_size;
  logic [TAG_W-1:0] Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [TAG_W-1:0] Dmem2proc_tag;
  modport master(
    input req_valid, req_cmd, req_addr, req_data, req_size,
    input Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    output req_ack, rsp_valid, rsp_data,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
  );
  modport slave(
    output req_valid, req_cmd, req_addr, req_data, req_size,
    output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    input req_ack, rsp_valid, rsp_data,
    input proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
  );
endinterface

// File: rtl/dmem_tag_table.sv
// dmem_tag_table: outstanding-load tag table with squash-drop and overwrite error
// Ports: clock, reset (async active-low), squash; alloc/alloc_tag/alloc_owner
// write an entry; ret_tag looks up and clears; deliver/ret_owner say whether and
// to whom the return goes; tag_err is sticky on allocation into a live entry.
module dmem_tag_table
  import dmem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic squash,
  input  logic alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [OWN_W-1:0] alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic deliver,
  output logic [OWN_W-1:0] ret_owner,
  output logic tag_err
);
  DMEM_TAG_ENTRY tbl [NUM_TAGS];
  DMEM_TAG_ENTRY ret;
  logic hit;
  assign ret = tbl[ret_tag];
  assign hit = ret_tag != '0 && ret.valid;
  assign ret_owner = ret.owner;
  // a load return arriving in the squash cycle is already stale
  assign deliver = hit && !ret.drop && !(squash && ret.owner == OWN_W'(REQ_LD));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tbl <= '{default: '0};
      tag_err <= 1'b0;
    end else begin
      // a same-cycle return frees the entry before the new allocation lands
      if (alloc && tbl[alloc_tag].valid && !(hit && ret_tag == alloc_tag)) tag_err <= 1'b1;
      for (int t = 1; t < NUM_TAGS; t++) begin
        if (squash && tbl[t].valid && tbl[t].owner == OWN_W'(REQ_LD)) tbl[t].drop <= 1'b1;
        if (hit && ret_tag == TAG_W'(t)) tbl[t] <= '0;
        if (alloc && alloc_tag == TAG_W'(t)) tbl[t] <= '{valid: 1'b1, owner: alloc_owner, drop: 1'b0};
      end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port among fetch, load and store requesters
// Ports: clock, reset (async active-low), squash, bus (dmem_arbiter_if.master),
// tag_err. With DMEM_ARB_STATS_EN defined, adds stat_grants, stat_rejects and
// stat_starve counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic squash,
  dmem_arbiter_if.master bus,
  output logic tag_err
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stat_grants,
  output logic [31:0] stat_rejects,
  output logic [31:0] stat_starve
`endif
);
  logic [NUM_REQ-1:0][CNT_W-1:0] starve_cnt;
  logic [OWN_W-1:0] win;
  logic [OWN_W-1:0] ret_owner;
  logic forced, issue, accepted, deliver;
  DMEM_REQ_PACKET pkt;
  // starved requesters override the fixed order; iterate downward so the lowest index wins
  always_comb begin
    forced = 1'b0;
    win = OWN_W'(REQ_FETCH);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && starve_cnt[i] == CNT_W'(STARVE_LIMIT)) begin
        forced = 1'b1;
        win = OWN_W'(i);
      end
    if (!forced)
      win = bus.req_valid[REQ_LD] ? OWN_W'(REQ_LD) : bus.req_valid[REQ_ST] ? OWN_W'(REQ_ST) : OWN_W'(REQ_FETCH);
  end
  assign issue = reset && |bus.req_valid;
  assign pkt = issue ? DMEM_REQ_PACKET'{cmd: bus.req_cmd[win], addr: bus.req_addr[win],
                                        data: bus.req_data[win], size: bus.req_size[win]} : '0;
  assign accepted = issue && bus.Dmem2proc_response != '0;
  assign bus.req_ack = accepted ? NUM_REQ'(1) << win : '0;
  assign bus.proc2Dmem_command = pkt.cmd;
  assign bus.proc2Dmem_addr = pkt.addr;
  assign bus.proc2Dmem_data = pkt.data;
  assign bus.proc2Dmem_size = pkt.size;
  always_ff @(posedge clock or negedge reset)
    if (!reset) starve_cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        starve_cnt[i] <= (!bus.req_valid[i] || bus.req_ack[i]) ? '0 :
                         starve_cnt[i] + CNT_W'(starve_cnt[i] != CNT_W'(STARVE_LIMIT));
  dmem_tag_table u_tags (
    .clock(clock),
    .reset(reset),
    .squash(squash),
    .alloc(accepted && pkt.cmd == BUS_LOAD),
    .alloc_tag(bus.Dmem2proc_response),
    .alloc_owner(win),
    .ret_tag(bus.Dmem2proc_tag),
    .deliver(deliver),
    .ret_owner(ret_owner),
    .tag_err(tag_err)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
    end else begin
      bus.rsp_valid <= deliver ? NUM_REQ'(1) << ret_owner : '0;
      if (deliver) bus.rsp_data <= bus.Dmem2proc_data;
    end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      stat_grants <= '0;
      stat_rejects <= '0;
      stat_starve <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stat_grants[i] <= stat_grants[i] + 32'(bus.req_ack[i]);
      stat_rejects <= stat_rejects + 32'(issue && !accepted);
      stat_starve <= stat_starve + 32'(issue && forced);
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand-written corner sequences for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic squash = 1'b0;
  logic tag_err;
`ifdef DMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_grants;
  logic [31:0] stat_rejects;
  logic [31:0] stat_starve;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dmem_arbiter_if bus();
  dmem_arbiter dut (
    .clock(clk),
    .reset(rst_n),
    .squash(squash),
    .bus(bus),
    .tag_err(tag_err)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_rejects(stat_rejects),
    .stat_starve(stat_starve)
`endif
  );
  typedef struct {
    logic [2:0] valid;
    logic [3:0] resp;
    logic [2:0] ack;
    int win;
  } vec_t;
  vec_t vecs [9];
  logic [31:0] addr_tab [3];
  logic [63:0] data_tab [3];
  BUS_COMMAND cmd_tab [3];
  MEM_SIZE size_tab [3];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] v, input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] d);
    bus.req_valid = v;
    bus.Dmem2proc_response = resp;
    bus.Dmem2proc_tag = tag;
    bus.Dmem2proc_data = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    addr_tab = '{32'h1000, 32'h2000, 32'h3000};
    data_tab = '{64'h0F0F, 64'h1111, 64'hCAFE_F00D};
    cmd_tab = '{BUS_LOAD, BUS_LOAD, BUS_STORE};
    size_tab = '{DOUBLE, WORD, HALF};
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i] = addr_tab[i];
      bus.req_data[i] = data_tab[i];
      bus.req_cmd[i] = cmd_tab[i];
      bus.req_size[i] = size_tab[i];
    end
    vecs[0] = '{3'b000, 4'd5, 3'b000, -1};
    vecs[1] = '{3'b001, 4'd9, 3'b001, 0};
    vecs[2] = '{3'b010, 4'd10, 3'b010, 1};
    vecs[3] = '{3'b100, 4'd11, 3'b100, 2};
    vecs[4] = '{3'b011, 4'd12, 3'b010, 1};
    vecs[5] = '{3'b101, 4'd13, 3'b100, 2};
    vecs[6] = '{3'b111, 4'd14, 3'b010, 1};
    vecs[7] = '{3'b110, 4'd0, 3'b000, 1};
    vecs[8] = '{3'b101, 4'd0, 3'b000, 2};
    drive(3'b111, 4'd5, 4'd0, 64'h0);
    #2;
    chk("reset ack", bus.req_ack, 3'b000);
    chk("reset cmd", bus.proc2Dmem_command, BUS_NONE);
    chk("reset rsp_valid", bus.rsp_valid, 3'b000);
    chk("reset rsp_data", bus.rsp_data, 64'h0);
    chk("reset tag_err", tag_err, 1'b0);
    drive(3'b000, 4'd0, 4'd0, 64'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].valid, vecs[k].resp, 4'd0, 64'h0);
      #1;
      chk($sformatf("vec%0d ack", k), bus.req_ack, vecs[k].ack);
      chk($sformatf("vec%0d cmd", k), bus.proc2Dmem_command, vecs[k].win < 0 ? BUS_NONE : cmd_tab[vecs[k].win]);
      chk($sformatf("vec%0d addr", k), bus.proc2Dmem_addr, vecs[k].win < 0 ? 32'h0 : addr_tab[vecs[k].win]);
      chk($sformatf("vec%0d data", k), bus.proc2Dmem_data, vecs[k].win < 0 ? 64'h0 : data_tab[vecs[k].win]);
      chk($sformatf("vec%0d size", k), bus.proc2Dmem_size, vecs[k].win < 0 ? BYTE : size_tab[vecs[k].win]);
      tick;
      drive(3'b000, 4'd0, 4'd0, 64'h0);
      tick;
    end
    chk("table tag_err", tag_err, 1'b0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    drive(3'b110, 4'd5, 4'd0, 64'h0);
    #1;
    chk("ldst ack", bus.req_ack, 3'b010);
    chk("ldst addr", bus.proc2Dmem_addr, 32'h2000);
    tick;
    drive(3'b100, 4'd6, 4'd0, 64'h0);
    #1;
    chk("st retry ack", bus.req_ack, 3'b100);
    chk("st retry cmd", bus.proc2Dmem_command, BUS_STORE);
    tick;
    drive(3'b000, 4'd0, 4'd5, 64'h55);
    tick;
    chk("tag5 rsp_valid", bus.rsp_valid, 3'b010);
    chk("tag5 rsp_data", bus.rsp_data, 64'h55);
    drive(3'b000, 4'd0, 4'd0, 64'h0);
    tick;
    chk("tag5 pulse", bus.rsp_valid, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      drive(3'b011, 4'd0, 4'd0, 64'h0);
      #1;
      chk($sformatf("starve c%0d ack", c), bus.req_ack, 3'b000);
      chk($sformatf("starve c%0d addr", c), bus.proc2Dmem_addr, 32'h2000);
      tick;
    end
    drive(3'b011, 4'd2, 4'd0, 64'h0);
    #1;
    chk("starve c5 addr", bus.proc2Dmem_addr, 32'h1000);
    chk("starve c5 ack", bus.req_ack, 3'b001);
    tick;
    drive(3'b000, 4'd0, 4'd0, 64'h0);
    tick;
    drive(3'b010, 4'd3, 4'd0, 64'h0);
    tick;
    drive(3'b000, 4'd0, 4'd3, 64'hDEAD_BEEF);
    tick;
    chk("tag3 rsp_valid", bus.rsp_valid, 3'b010);
    chk("tag3 rsp_data", bus.rsp_data, 64'hDEAD_BEEF);
    drive(3'b000, 4'd0, 4'd3, 64'h1234);
    tick;
    chk("tag3 cleared", bus.rsp_valid, 3'b000);
    drive(3'b010, 4'd7, 4'd0, 64'h0);
    tick;
    squash = 1'b1;
    drive(3'b001, 4'd8, 4'd0, 64'h0);
    #1;
    chk("squash fetch ack", bus.req_ack, 3'b001);
    tick;
    squash = 1'b0;
    drive(3'b000, 4'd0, 4'd7, 64'h777);
    tick;
    chk("squashed tag7", bus.rsp_valid, 3'b000);
    drive(3'b000, 4'd0, 4'd8, 64'h888);
    tick;
    chk("fetch tag8 rsp_valid", bus.rsp_valid, 3'b001);
    chk("fetch tag8 rsp_data", bus.rsp_data, 64'h888);
    drive(3'b010, 4'd4, 4'd0, 64'h0);
    tick;
    drive(3'b001, 4'd4, 4'd4, 64'h4444);
    tick;
    chk("tag4 same-cycle rsp_valid", bus.rsp_valid, 3'b010);
    chk("tag4 same-cycle rsp_data", bus.rsp_data, 64'h4444);
    chk("tag4 same-cycle tag_err", tag_err, 1'b0);
    drive(3'b001, 4'd4, 4'd0, 64'h0);
    tick;
    chk("tag4 overwrite tag_err", tag_err, 1'b1);
    drive(3'b000, 4'd0, 4'd4, 64'h4545);
    tick;
    chk("tag4 fetch owner", bus.rsp_valid, 3'b001);
    drive(3'b000, 4'd0, 4'd0, 64'h0);
    tick;
    chk("tag_err sticky", tag_err, 1'b1);
    drive(3'b010, 4'd6, 4'd0, 64'h0);
    tick;
    drive(3'b101, 4'd9, 4'd0, 64'h0);
    #1;
    chk("pre-reset cmd", bus.proc2Dmem_command, BUS_STORE);
    rst_n = 1'b0;
    #1;
    chk("mid reset cmd", bus.proc2Dmem_command, BUS_NONE);
    chk("mid reset ack", bus.req_ack, 3'b000);
    chk("mid reset tag_err", tag_err, 1'b0);
    tick;
    rst_n = 1'b1;
    drive(3'b000, 4'd0, 4'd6, 64'h66);
    tick;
    chk("old tag6 after reset", bus.rsp_valid, 3'b000);
    drive(3'b000, 4'd0, 4'd2, 64'h22);
    tick;
    chk("old tag2 after reset", bus.rsp_valid, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
